// File: rtl/riscmakers_cache_refill_ctrl.sv
// Single-port data store arbiter: multi-beat line refill > core write > core read; 1-cycle read latency.
// Optional RISCMAKERS_REFILL_ABORT_EN adds refill_abort_i to drop an in-flight refill without a done pulse.
module riscmakers_cache_refill_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 256,
    parameter int MEM_WIDTH  = 64,
    localparam int ADDR_W    = $clog2(NUM_WORDS),
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  refill_req_i,
    input  logic [ADDR_W-1:0]     refill_idx_i,
    output logic                  refill_busy_o,
    output logic                  refill_done_o,
`ifdef RISCMAKERS_REFILL_ABORT_EN
    input  logic                  refill_abort_i,
`endif
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [MEM_WIDTH-1:0]  mem_data_i,
    input  logic                  wr_req_i,
    input  logic [ADDR_W-1:0]     wr_idx_i,
    input  logic [BE_W-1:0]       wr_be_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_gnt_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_idx_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [BE_W-1:0]       sram_be_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
    localparam int BEATS  = DATA_WIDTH / MEM_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MB     = MEM_WIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state_q, state_n;
    logic [BEAT_W-1:0]   beat_q, beat_n;
    logic [ADDR_W-1:0]   idx_q, idx_n;
    logic                done_q, done_n;
    logic                busy_q;
    logic                rd_valid_q;
    logic                abort;

`ifdef RISCMAKERS_REFILL_ABORT_EN
    assign abort = refill_abort_i;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            beat_q     <= beat_n;
            idx_q      <= idx_n;
            done_q     <= done_n;
            busy_q     <= (state_n == FILL);
            rd_valid_q <= rd_gnt_o;
        end
    end

    always_comb begin
        state_n = state_q;
        beat_n  = beat_q;
        idx_n   = idx_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    state_n = FILL;
                    idx_n   = refill_idx_i;
                    beat_n  = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_n = IDLE;
                    beat_n  = '0;
                end else if (mem_valid_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_n = IDLE;
                        beat_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_ready_o  = 1'b0;
        wr_gnt_o     = 1'b0;
        rd_gnt_o     = 1'b0;
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (refill_req_i) begin
                        // refill start cycle only latches the index; the port stays idle
                    end else if (wr_req_i) begin
                        wr_gnt_o     = 1'b1;
                        sram_en_o    = 1'b1;
                        sram_we_o    = 1'b1;
                        sram_be_o    = wr_be_i;
                        sram_addr_o  = wr_idx_i;
                        sram_wdata_o = wr_data_i;
                    end else if (rd_req_i) begin
                        rd_gnt_o    = 1'b1;
                        sram_en_o   = 1'b1;
                        sram_addr_o = rd_idx_i;
                    end
                end
                FILL: begin
                    mem_ready_o = !abort;
                    if (mem_valid_i && !abort) begin
                        sram_en_o    = 1'b1;
                        sram_we_o    = 1'b1;
                        sram_addr_o  = idx_q;
                        sram_wdata_o = {BEATS{mem_data_i}};
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_q == BEAT_W'(b)) sram_be_o[b*MB +: MB] = '1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign refill_busy_o = busy_q;
    assign refill_done_o = done_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_valid_q ? sram_rdata_i : '0;
endmodule

// File: tb/tb_riscmakers_cache_refill_ctrl.sv
// Bench for riscmakers_cache_refill_ctrl: behavioural data store plus a reference line array feeding a read scoreboard.
module tb_riscmakers_cache_refill_ctrl;
    localparam int DW = 128;
    localparam int NW = 256;
    localparam int MW = 64;
    localparam int AW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          refill_req = 1'b0;
    logic [AW-1:0] refill_idx = '0;
    logic          refill_busy, refill_done;
    logic          refill_abort = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [MW-1:0] mem_data = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_idx = '0;
    logic [BW-1:0] wr_be = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_idx = '0;
    logic          rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic          sram_en, sram_we;
    logic [BW-1:0] sram_be;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] sram_mem [NW];
    logic [DW-1:0] ref_mem  [NW];
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscmakers_cache_refill_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MEM_WIDTH(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .refill_req_i(refill_req), .refill_idx_i(refill_idx),
        .refill_busy_o(refill_busy), .refill_done_o(refill_done),
`ifdef RISCMAKERS_REFILL_ABORT_EN
        .refill_abort_i(refill_abort),
`endif
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_data_i(mem_data),
        .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_be_i(wr_be), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_be_o(sram_be),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    // single-port data store: write array or capture read data on the same edge
    always @(posedge clk) begin
        if (sram_en === 1'b1) begin
            if (sram_we === 1'b1) begin
                for (int i = 0; i < BW; i++)
                    if (sram_be[i]) sram_mem[sram_addr][i*8 +: 8] <= sram_wdata[i*8 +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got=%h required=no read outstanding", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_data got=%h required=%h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic ref_write(input logic [AW-1:0] idx, input logic [BW-1:0] be, input logic [DW-1:0] d);
        for (int i = 0; i < BW; i++)
            if (be[i]) ref_mem[idx][i*8 +: 8] = d[i*8 +: 8];
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        wr_req = 1'b1; rd_req = 1'b1; wr_be = '1;
        cyc(); #1;
        checks++; if (sram_en !== 1'b0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL reset_comb got en=%b wg=%b rg=%b mr=%b required=0", sram_en, wr_gnt, rd_gnt, mem_ready); end
        checks++; if (refill_busy !== 1'b0 || refill_done !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL reset_regs got busy=%b done=%b rv=%b required=0", refill_busy, refill_done, rd_valid); end
        wr_req = 1'b0; rd_req = 1'b0; wr_be = '0;
        cyc(); rst = 1'b0; #1;
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h required=0", rd_data); end
    endtask

    task automatic test_basic_refill();
        logic [MW-1:0] b0, b1;
        b0 = 64'h1111111111111111; b1 = 64'h2222222222222222;
        cyc(); refill_req = 1'b1; refill_idx = 8'd5; #1;
        checks++; if (sram_en !== 1'b0) begin failures++; $display("FAIL basic_start_en got=%b required=0", sram_en); end
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = b0; #1;
        checks++; if (refill_busy !== 1'b1 || mem_ready !== 1'b1) begin
            failures++; $display("FAIL basic_busy got busy=%b ready=%b required=1", refill_busy, mem_ready); end
        checks++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 8'd5 || sram_be !== 16'h00FF || sram_wdata !== {2{b0}}) begin
            failures++; $display("FAIL basic_beat0 got en=%b we=%b a=%h be=%h wd=%h required 1 1 05 00ff", sram_en, sram_we, sram_addr, sram_be, sram_wdata); end
        cyc(); mem_data = b1; #1;
        checks++; if (sram_en !== 1'b1 || sram_addr !== 8'd5 || sram_be !== 16'hFF00 || sram_wdata !== {2{b1}}) begin
            failures++; $display("FAIL basic_beat1 got en=%b a=%h be=%h wd=%h required 1 05 ff00", sram_en, sram_addr, sram_be, sram_wdata); end
        ref_write(8'd5, 16'h00FF, {2{b0}});
        ref_write(8'd5, 16'hFF00, {2{b1}});
        cyc(); mem_valid = 1'b0; rd_req = 1'b1; rd_idx = 8'd5; #1;
        checks++; if (refill_done !== 1'b1 || refill_busy !== 1'b0) begin
            failures++; $display("FAIL basic_done got done=%b busy=%b required 1 0", refill_done, refill_busy); end
        checks++; if (rd_gnt !== 1'b1 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 8'd5) begin
            failures++; $display("FAIL basic_rd_issue got g=%b en=%b we=%b a=%h required 1 1 0 05", rd_gnt, sram_en, sram_we, sram_addr); end
        exp_q.push_back(ref_mem[5]);
        cyc(); rd_req = 1'b0; #1;
        checks++; if (refill_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b required=0", refill_done); end
    endtask

    task automatic test_beat_gaps();
        logic [MW-1:0] b0, b1;
        b0 = 64'h0123456789ABCDEF; b1 = 64'hFEDCBA9876543210;
        cyc(); refill_req = 1'b1; refill_idx = 8'd9;
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = b0;
        for (int g = 0; g < 3; g++) begin
            cyc(); mem_valid = 1'b0; mem_data = '1; #1;
            checks++; if (sram_en !== 1'b0 || mem_ready !== 1'b1 || refill_busy !== 1'b1) begin
                failures++; $display("FAIL gap%0d got en=%b ready=%b busy=%b required 0 1 1", g, sram_en, mem_ready, refill_busy); end
        end
        cyc(); mem_valid = 1'b1; mem_data = b1; #1;
        checks++; if (sram_be !== 16'hFF00 || sram_addr !== 8'd9) begin
            failures++; $display("FAIL gap_beat1 got be=%h a=%h required ff00 09", sram_be, sram_addr); end
        ref_write(8'd9, '1, {b1, b0});
        cyc(); mem_valid = 1'b0; rd_req = 1'b1; rd_idx = 8'd9; #1;
        checks++; if (refill_done !== 1'b1 || rd_gnt !== 1'b1) begin
            failures++; $display("FAIL gap_done got done=%b rg=%b required 1 1", refill_done, rd_gnt); end
        exp_q.push_back(ref_mem[9]);
        cyc(); rd_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] wd;
        wd = {4{32'h5A5AF00D}};
        cyc(); refill_req = 1'b1; refill_idx = 8'd3;
        wr_req = 1'b1; wr_idx = 8'd12; wr_be = '1; wr_data = wd;
        rd_req = 1'b1; rd_idx = 8'd9; #1;
        checks++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || sram_en !== 1'b0) begin
            failures++; $display("FAIL simul_start got wg=%b rg=%b en=%b required 0 0 0", wr_gnt, rd_gnt, sram_en); end
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = 64'hAAAA0000BBBB0000; #1;
        checks++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || sram_addr !== 8'd3) begin
            failures++; $display("FAIL simul_fill got wg=%b rg=%b a=%h required 0 0 03", wr_gnt, rd_gnt, sram_addr); end
        cyc(); mem_data = 64'hCCCC0000DDDD0000;
        ref_write(8'd3, '1, {64'hCCCC0000DDDD0000, 64'hAAAA0000BBBB0000});
        cyc(); mem_valid = 1'b0; #1;
        checks++; if (refill_done !== 1'b1 || wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || sram_addr !== 8'd12 || sram_we !== 1'b1) begin
            failures++; $display("FAIL simul_wr_after got done=%b wg=%b rg=%b a=%h we=%b required 1 1 0 0c 1", refill_done, wr_gnt, rd_gnt, sram_addr, sram_we); end
        ref_write(8'd12, '1, wd);
        cyc(); wr_req = 1'b0; #1;
        checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL simul_rd got=%b required=1", rd_gnt); end
        exp_q.push_back(ref_mem[9]);
        cyc(); rd_req = 1'b0;
    endtask

    task automatic test_be_write_read();
        cyc(); wr_req = 1'b1; wr_idx = 8'd7; wr_be = 16'h000F; wr_data = 128'hDEADBEEF; #1;
        checks++; if (wr_gnt !== 1'b1 || sram_be !== 16'h000F) begin
            failures++; $display("FAIL be_wr got g=%b be=%h required 1 000f", wr_gnt, sram_be); end
        ref_write(8'd7, 16'h000F, 128'hDEADBEEF);
        cyc(); wr_req = 1'b0; rd_req = 1'b1; rd_idx = 8'd7; #1;
        checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL be_rd_gnt got=%b required=1", rd_gnt); end
        exp_q.push_back(ref_mem[7]);
        cyc(); rd_req = 1'b0; #1;
        checks++; if (rd_valid !== 1'b1 || rd_data[31:0] !== 32'hDEADBEEF || rd_data[127:32] !== ref_mem[7][127:32]) begin
            failures++; $display("FAIL be_rd_data got v=%b d=%h required 1 %h", rd_valid, rd_data, ref_mem[7]); end
    endtask

    task automatic test_reset_mid_refill();
        cyc(); refill_req = 1'b1; refill_idx = 8'd20;
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = 64'h7777777777777777;
        ref_write(8'd20, 16'h00FF, {2{64'h7777777777777777}});
        cyc(); rst = 1'b1; mem_valid = 1'b0;
        cyc(); rst = 1'b0; #1;
        checks++; if (refill_busy !== 1'b0 || refill_done !== 1'b0) begin
            failures++; $display("FAIL rstmid got busy=%b done=%b required 0 0", refill_busy, refill_done); end
        cyc(); #1;
        checks++; if (refill_done !== 1'b0) begin failures++; $display("FAIL rstmid_nodone got=%b required=0", refill_done); end
        cyc(); refill_req = 1'b1; refill_idx = 8'd21;
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = 64'h8888888888888888; #1;
        checks++; if (sram_be !== 16'h00FF || sram_addr !== 8'd21) begin
            failures++; $display("FAIL rstmid_beat0 got be=%h a=%h required 00ff 15", sram_be, sram_addr); end
        cyc(); mem_data = 64'h9999999999999999;
        ref_write(8'd21, '1, {64'h9999999999999999, 64'h8888888888888888});
        cyc(); mem_valid = 1'b0; #1;
        checks++; if (refill_done !== 1'b1) begin failures++; $display("FAIL rstmid_done2 got=%b required=1", refill_done); end
    endtask

`ifdef RISCMAKERS_REFILL_ABORT_EN
    task automatic test_abort();
        cyc(); refill_req = 1'b1; refill_idx = 8'd30;
        cyc(); refill_req = 1'b0; mem_valid = 1'b1; mem_data = 64'h3333333333333333;
        ref_write(8'd30, 16'h00FF, {2{64'h3333333333333333}});
        cyc(); mem_data = 64'h4444444444444444; refill_abort = 1'b1; #1;
        checks++; if (sram_en !== 1'b0 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL abort_cycle got en=%b ready=%b required 0 0", sram_en, mem_ready); end
        cyc(); refill_abort = 1'b0; mem_valid = 1'b0;
        wr_req = 1'b1; wr_idx = 8'd31; wr_be = '1; wr_data = {4{32'h0BADCAFE}}; #1;
        checks++; if (refill_busy !== 1'b0 || refill_done !== 1'b0 || wr_gnt !== 1'b1) begin
            failures++; $display("FAIL abort_idle got busy=%b done=%b wg=%b required 0 0 1", refill_busy, refill_done, wr_gnt); end
        ref_write(8'd31, '1, {4{32'h0BADCAFE}});
        cyc(); wr_req = 1'b0; rd_req = 1'b1; rd_idx = 8'd30;
        exp_q.push_back(ref_mem[30]);
        cyc(); rd_req = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [AW-1:0] idxs [5];
        idxs = '{8'd5, 8'd9, 8'd7, 8'd12, 8'd21};
        for (int k = 0; k < 5; k++) begin
            cyc(); rd_req = 1'b1; rd_idx = idxs[k]; #1;
            checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d got=%b required=1", k, rd_gnt); end
            exp_q.push_back(ref_mem[idxs[k]]);
        end
        cyc(); rd_req = 1'b0;
        cyc(); cyc(); #1;
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL reads_outstanding got=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            sram_mem[i] = {4{32'hC0DE0000 | 32'(i)}};
            ref_mem[i]  = {4{32'hC0DE0000 | 32'(i)}};
        end
        test_reset();
        test_basic_refill();
        test_beat_gaps();
        test_simultaneous();
        test_be_write_read();
        test_reset_mid_refill();
`ifdef RISCMAKERS_REFILL_ABORT_EN
        test_abort();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
